// File: rtl/branch_redirect_ctrl.sv
// branch_redirect_ctrl
// Sequences the PC redirect that follows a taken branch or jump resolved in EX.
// A taken branch is accepted only while the controller is idle. Its target is
// latched, and the PC is loaded once the I-side fetch is no longer busy. The
// wrong-path IF/ID and ID/EX contents are squashed around the redirect. Two
// saturating performance counters track accepted redirects and the cycles
// spent waiting on the fetch.
module branch_redirect_ctrl #(
  parameter int unsigned SQUASH_CYCLES = 1,   // extra IF/ID flush cycles after load_pc (0..7)
  parameter int unsigned COUNT_W       = 16   // performance counter width
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               ex_valid,
  input  logic               branch_enable,
  input  logic [15:0]        br_addr,
  input  logic [1:0]         pcmux_sel,
  input  logic               mem_stall,
  input  logic               if_busy,
  input  logic               cnt_clear,
  output logic               load_pc,
  output logic [15:0]        pc_redirect,
  output logic [1:0]         pc_redirect_sel,
  output logic               flush_if_id,
  output logic               flush_id_ex,
  output logic               stall_fetch,
  output logic               redirect_pending,
  output logic [COUNT_W-1:0] br_taken_cnt,
  output logic [COUNT_W-1:0] redirect_wait_cnt
);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_FETCH = 2'd1,
    REDIRECT   = 2'd2,
    SQUASH     = 2'd3
  } state_t;

  localparam int unsigned      SQ_LOAD = (SQUASH_CYCLES == 0) ? 0 : SQUASH_CYCLES - 1;
  localparam logic [2:0]       SQ_INIT = 3'(SQ_LOAD);
  localparam logic [COUNT_W-1:0] CNT_MAX = '1;
  localparam logic [COUNT_W-1:0] CNT_ONE = {{(COUNT_W-1){1'b0}}, 1'b1};

  state_t             state_q, state_d;
  logic [2:0]         squash_cnt_q;
  logic [15:0]        target_q;
  logic [1:0]         sel_q;
  logic               load_pc_q;
  logic               stall_fetch_q;
  logic               pending_q;
  logic [COUNT_W-1:0] br_taken_cnt_q;
  logic [COUNT_W-1:0] wait_cnt_q;
  logic               accept;

  // Reset is folded into accept so that a branch presented during reset
  // neither flushes nor counts. Reset therefore always wins.
  assign accept = ~reset & (state_q == IDLE) & ex_valid & branch_enable & ~mem_stall;

  // Next-state decision for the redirect sequencer
  always_comb begin
    // NOTE: default first so every path assigns state_d; otherwise a latch is inferred.
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (accept) state_d = if_busy ? WAIT_FETCH : REDIRECT;
      end
      WAIT_FETCH: begin
        if (!if_busy) state_d = REDIRECT;
      end
      REDIRECT: begin
        state_d = (SQUASH_CYCLES == 0) ? IDLE : SQUASH;
      end
      SQUASH: begin
        if (squash_cnt_q == 3'd0) state_d = IDLE;
      end
    endcase
  end

  // FSM state, target latches, squash countdown and registered status outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the target latches are reset too, so a dropped redirect leaves no stale target behind.
      state_q       <= IDLE;
      squash_cnt_q  <= 3'd0;
      target_q      <= 16'h0000;
      sel_q         <= 2'b00;
      load_pc_q     <= 1'b0;
      stall_fetch_q <= 1'b0;
      pending_q     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every register sampling pre-edge values.
      state_q       <= state_d;
      load_pc_q     <= (state_d == REDIRECT);
      stall_fetch_q <= (state_d == WAIT_FETCH);
      pending_q     <= (state_d != IDLE);
      if (accept) begin
        target_q <= br_addr;
        sel_q    <= pcmux_sel;
      end
      if (state_q == REDIRECT) begin
        squash_cnt_q <= SQ_INIT;
      end else if (state_q == SQUASH && squash_cnt_q != 3'd0) begin
        squash_cnt_q <= squash_cnt_q - 3'd1;
      end
    end
  end

  // Saturating count of accepted redirects; a clear beats an increment
  always_ff @(posedge clk) begin
    if (reset || cnt_clear) begin
      br_taken_cnt_q <= '0;
    end else if (accept && br_taken_cnt_q != CNT_MAX) begin
      br_taken_cnt_q <= br_taken_cnt_q + CNT_ONE;
    end
  end

  // Saturating count of cycles spent waiting for the fetch to go idle
  always_ff @(posedge clk) begin
    if (reset || cnt_clear) begin
      wait_cnt_q <= '0;
    end else if (state_q == WAIT_FETCH && wait_cnt_q != CNT_MAX) begin
      wait_cnt_q <= wait_cnt_q + CNT_ONE;
    end
  end

  assign load_pc           = load_pc_q;
  assign pc_redirect       = load_pc_q ? target_q : 16'h0000;
  assign pc_redirect_sel   = load_pc_q ? sel_q : 2'b00;
  assign stall_fetch       = stall_fetch_q;
  assign redirect_pending  = pending_q;
  assign flush_if_id       = accept | (state_q != IDLE);
  assign flush_id_ex       = accept | (state_q == WAIT_FETCH) | (state_q == REDIRECT);
  assign br_taken_cnt      = br_taken_cnt_q;
  assign redirect_wait_cnt = wait_cnt_q;

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Bench for branch_redirect_ctrl. Directed scenarios are followed by random
// traffic. Every cycle is checked against a behavioural model of the
// redirect rules.
module tb_branch_redirect_ctrl;

  localparam int unsigned SQ  = 1;
  localparam int unsigned CW  = 4;
  localparam int          MAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          reset, ex_valid, branch_enable, mem_stall, if_busy, cnt_clear;
  logic [15:0]   br_addr;
  logic [1:0]    pcmux_sel;
  logic          load_pc, flush_if_id, flush_id_ex, stall_fetch, redirect_pending;
  logic [15:0]   pc_redirect;
  logic [1:0]    pc_redirect_sel;
  logic [CW-1:0] br_taken_cnt, redirect_wait_cnt;

  int checks = 0;
  int errors = 0;

  // Model of the controller: where the pending redirect stands, plus the counters
  bit        m_waiting;      // accepted, fetch still busy
  bit        m_loading;      // PC load happens this cycle
  int        m_squash_left;  // remaining post-load squash cycles
  int        m_target, m_sel;
  int        m_taken, m_waits;

  always #5 clk = ~clk;

  branch_redirect_ctrl #(.SQUASH_CYCLES(SQ), .COUNT_W(CW)) dut (
    .clk(clk), .reset(reset), .ex_valid(ex_valid), .branch_enable(branch_enable),
    .br_addr(br_addr), .pcmux_sel(pcmux_sel), .mem_stall(mem_stall),
    .if_busy(if_busy), .cnt_clear(cnt_clear), .load_pc(load_pc),
    .pc_redirect(pc_redirect), .pc_redirect_sel(pc_redirect_sel),
    .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex), .stall_fetch(stall_fetch),
    .redirect_pending(redirect_pending), .br_taken_cnt(br_taken_cnt),
    .redirect_wait_cnt(redirect_wait_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int sat_inc(input int v);
    return (v >= MAX) ? MAX : v + 1;
  endfunction

  // One clock cycle: drive the inputs, check the outputs mid-cycle, then advance the model at the edge
  task automatic step(input bit r, input bit ev, input bit be, input logic [15:0] a,
                      input logic [1:0] s, input bit ms, input bit ib, input bit cc);
    bit busy_phase, acc;
    @(negedge clk);
    reset = r; ex_valid = ev; branch_enable = be; br_addr = a;
    pcmux_sel = s; mem_stall = ms; if_busy = ib; cnt_clear = cc;
    #1;
    busy_phase = m_waiting || m_loading || (m_squash_left > 0);
    acc = !r && !busy_phase && ev && be && !ms;
    check("load_pc", load_pc, m_loading);
    check("pc_redirect", pc_redirect, m_loading ? m_target : 0);
    check("pc_redirect_sel", pc_redirect_sel, m_loading ? m_sel : 0);
    check("flush_if_id", flush_if_id, acc || busy_phase);
    check("flush_id_ex", flush_id_ex, acc || m_waiting || m_loading);
    check("stall_fetch", stall_fetch, m_waiting);
    check("redirect_pending", redirect_pending, busy_phase);
    check("br_taken_cnt", br_taken_cnt, m_taken);
    check("redirect_wait_cnt", redirect_wait_cnt, m_waits);
    @(posedge clk);
    if (r) begin
      m_waiting = 0; m_loading = 0; m_squash_left = 0;
      m_target = 0; m_sel = 0; m_taken = 0; m_waits = 0;
    end else begin
      m_taken = cc ? 0 : (acc ? sat_inc(m_taken) : m_taken);
      m_waits = cc ? 0 : (m_waiting ? sat_inc(m_waits) : m_waits);
      if (acc) begin
        m_target = a; m_sel = s;
        m_waiting = ib; m_loading = !ib;
      end else if (m_waiting) begin
        m_waiting = ib; m_loading = !ib;
      end else if (m_loading) begin
        m_loading = 0; m_squash_left = SQ;
      end else if (m_squash_left > 0) begin
        m_squash_left--;
      end
    end
  endtask

  task automatic idle(input bit ib = 0);
    step(0, 0, 0, 16'h0, 2'b00, 0, ib, 0);
  endtask

  task automatic take(input logic [15:0] a, input bit ib = 0);
    step(0, 1, 1, a, 2'b01, 0, ib, 0);
  endtask

  initial begin
    bit ib_r;
    m_waiting = 0; m_loading = 0; m_squash_left = 0;
    m_target = 0; m_sel = 0; m_taken = 0; m_waits = 0;
    reset = 1; ex_valid = 0; branch_enable = 0; br_addr = '0;
    pcmux_sel = '0; mem_stall = 0; if_busy = 0; cnt_clear = 0;
    repeat (2) @(posedge clk);

    // Reset state, then a redirect with the fetch idle
    step(1, 1, 1, 16'h1111, 2'b11, 0, 0, 0);
    take(16'h3A40);
    idle(); idle(); idle();
    #2 check("dir_taken_1", br_taken_cnt, 1);

    // Redirect with the fetch busy for three cycles
    take(16'h5550, 1); idle(1); idle(1); idle(0);
    #2 check("dir_load_after_wait", load_pc, 1);
    check("dir_wait_cnt_3", redirect_wait_cnt, 3);
    idle(); idle();

    // mem_stall holds off acceptance; the first unstalled cycle accepts
    repeat (4) step(0, 1, 1, 16'h0BEE, 2'b10, 1, 0, 0);
    step(0, 1, 1, 16'h0BEE, 2'b10, 0, 0, 0);
    idle(); idle();
    #2 check("dir_taken_3", br_taken_cnt, 3);

    // Wrong-path branches during REDIRECT and SQUASH are ignored
    take(16'h7000); take(16'h7100); take(16'h7200);
    idle();
    #2 check("dir_taken_4", br_taken_cnt, 4);

    // Reset mid-WAIT_FETCH drops the redirect
    take(16'h6000, 1); idle(1);
    step(1, 0, 0, 16'h0, 2'b00, 0, 1, 0);
    idle(1); idle(0); idle(0);
    #2 check("dir_no_load_after_reset", load_pc, 0);

    // Saturation and clear-over-increment
    for (int i = 0; i < 17; i++) begin
      take(16'(i * 4)); idle(); idle();
    end
    #2 check("dir_taken_sat", br_taken_cnt, MAX);
    step(0, 1, 1, 16'h4444, 2'b01, 0, 0, 1);
    #2 check("dir_clear_wins", br_taken_cnt, 0);
    idle(); idle();

    // Random traffic
    ib_r = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0) ib_r = ~ib_r;
      step($urandom_range(0, 99) < 2,
           $urandom_range(0, 9) < 8,
           $urandom_range(0, 9) < 3,
           16'($urandom),
           2'($urandom),
           $urandom_range(0, 4) == 0,
           ib_r,
           $urandom_range(0, 99) < 3);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
